// File: rtl/sim_ctrl_mmio.sv
// Simulation-control peripheral beside core_top: snoops DCCM writes and the
// retirement strobe to provide console channels, a finish mailbox, a
// no-retire watchdog and cycle/retire counters.
module sim_ctrl_mmio #(
  parameter int              XLEN         = 32,
  parameter int              N_CHAN       = 4,
  parameter logic [XLEN-1:0] CON_BASE     = 32'h0020_0000,
  parameter logic [XLEN-1:0] FINISH_ADDR  = 32'h1000_0000,
  parameter int              FIFO_DEPTH   = 16,
  parameter int              WDOG_TIMEOUT = 10000,
  parameter int              CNT_W        = 48,
  localparam int             CHW          = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dccm_wen,
  input  logic [XLEN-1:0]  dccm_waddr,
  input  logic [XLEN-1:0]  dccm_wdata,
  input  logic             retire_valid,
  output logic             con_valid,
  input  logic             con_ready,
  output logic [7:0]       con_data,
  output logic [CHW-1:0]   con_chan,
  output logic             con_overflow,
  output logic [1:0]       state,
  output logic             done,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(WDOG_TIMEOUT + 1);
  localparam int EW  = CHW + 8;

  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_FIN = 2'b01,
    S_TMO = 2'b10
  } state_e;

  state_e         st_q;
  logic [WDW-1:0] wdog_cnt;

  // Address decode: word offset from the console base selects the channel,
  // byte lane bits are ignored. The finish mailbox needs an exact match.
  logic [XLEN-3:0] word_off;
  logic            con_hit, fin_hit, run;

  assign word_off = dccm_waddr[XLEN-1:2] - CON_BASE[XLEN-1:2];
  assign con_hit  = dccm_wen && (word_off < (XLEN-2)'(N_CHAN));
  assign fin_hit  = dccm_wen && (dccm_waddr == FINISH_ADDR);
  assign run      = (st_q == S_RUN);
  assign state    = st_q;
  assign done     = (st_q != S_RUN);

  // Run-state FSM, watchdog, counters and exit-code capture; terminal states
  // freeze everything here until reset. Finish takes priority over timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= S_RUN;
      wdog_cnt     <= '0;
      exit_code    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (run) begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (retire_valid) begin
        retire_count <= retire_count + CNT_W'(1);
        wdog_cnt     <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + WDW'(1);
      end
      if (fin_hit) begin
        st_q      <= S_FIN;
        exit_code <= dccm_wdata;
      end else if (!retire_valid && wdog_cnt == WDW'(WDOG_TIMEOUT - 1)) begin
        st_q <= S_TMO;
      end
    end
  end

  // Console FIFO: extra pointer bit separates full from empty. A pop frees
  // a slot in the same cycle, so full+push+pop is accepted without loss.
  logic [FIFO_DEPTH-1:0][EW-1:0] mem;
  logic [AW:0]                   wr_ptr, rd_ptr, rd_nxt;
  logic                          full, pop, push, head_vld;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = con_valid && con_ready;
  assign push     = con_hit && run && (!full || pop);
  assign rd_nxt   = rd_ptr + (AW+1)'(pop);
  assign head_vld = (wr_ptr != rd_nxt);

  // Storage write; entries are only read once the pointers say they exist.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {word_off[CHW-1:0], dccm_wdata[7:0]};
  end

  // Pointers and the registered head view. The head is taken from entries
  // already stored before this edge, which gives the one-cycle push-to-valid
  // latency and keeps dccm_* off any combinational path to con_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      con_valid    <= 1'b0;
      con_data     <= '0;
      con_chan     <= '0;
      con_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr <= rd_nxt;
      if (con_hit && run && full && !pop) con_overflow <= 1'b1;
      con_valid <= head_vld;
      if (head_vld) {con_chan, con_data} <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// Self-checking bench for sim_ctrl_mmio: directed vector table, hand-written
// corner sequences and random traffic, all compared against a queue model.
module tb_sim_ctrl_mmio;

  localparam int          DEPTH    = 16;
  localparam int          WDOG     = 8;
  localparam int          NCH      = 4;
  localparam logic [31:0] CON_BASE = 32'h0020_0000;
  localparam logic [31:0] FIN      = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dccm_wen;
  logic [31:0] dccm_waddr, dccm_wdata;
  logic        retire_valid;
  logic        con_valid, con_ready, con_overflow, done;
  logic [7:0]  con_data;
  logic [1:0]  con_chan;
  logic [1:0]  state;
  logic [31:0] exit_code;
  logic [47:0] cycle_count, retire_count;

  always #5 clk = ~clk;

  sim_ctrl_mmio #(.N_CHAN(NCH), .FIFO_DEPTH(DEPTH), .WDOG_TIMEOUT(WDOG)) dut (
    .clk(clk), .rst(rst), .dccm_wen(dccm_wen), .dccm_waddr(dccm_waddr),
    .dccm_wdata(dccm_wdata), .retire_valid(retire_valid),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .con_chan(con_chan), .con_overflow(con_overflow), .state(state),
    .done(done), .exit_code(exit_code), .cycle_count(cycle_count),
    .retire_count(retire_count));

  int checks = 0, failures = 0;

  // Reference model: queue of pending bytes stamped with their enqueue edge.
  typedef struct {int ch; int b; int t;} ent_t;
  ent_t   q[$];
  int     m_state, m_idle, n_edge;
  longint m_cyc, m_ret, m_exit;
  bit     m_ovf, m_vis;

  typedef struct {
    bit wen; logic [31:0] addr; logic [31:0] data; bit rdy;
    bit ev; int ed; int ec;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit wen, input logic [31:0] a, input logic [31:0] d,
                       input bit ret, input bit rdy);
    dccm_wen = wen; dccm_waddr = a; dccm_wdata = d;
    retire_valid = ret; con_ready = rdy;
  endtask

  // Advance the model by one clock using the current inputs, clock the DUT,
  // then compare every output against the model.
  task automatic step();
    bit run, pop, chit;
    int sz;
    longint word, base;
    if (rst) begin
      q.delete();
      m_state = 0; m_idle = 0; m_cyc = 0; m_ret = 0; m_exit = 0; m_ovf = 0;
    end else begin
      run  = (m_state == 0);
      pop  = m_vis && con_ready;
      sz   = q.size();
      word = longint'(dccm_waddr) >> 2;
      base = longint'(CON_BASE) >> 2;
      chit = dccm_wen && word >= base && word < base + NCH;
      if (pop) void'(q.pop_front());
      if (run && chit) begin
        if (sz == DEPTH && !pop) m_ovf = 1;
        else q.push_back('{int'(word - base), int'(dccm_wdata & 32'hFF), n_edge});
      end
      if (run) begin
        m_cyc++;
        if (retire_valid) m_ret++;
        m_idle = retire_valid ? 0 : m_idle + 1;
        if (dccm_wen && dccm_waddr == FIN) begin
          m_state = 1; m_exit = longint'(dccm_wdata);
        end else if (m_idle == WDOG) begin
          m_state = 2;
        end
      end
    end
    m_vis = !rst && q.size() > 0 && q[0].t < n_edge;
    @(posedge clk);
    n_edge++;
    #1;
    chk("state", state, m_state);
    chk("done", done, m_state != 0);
    chk("exit_code", exit_code, m_exit);
    chk("cycle_count", cycle_count, m_cyc);
    chk("retire_count", retire_count, m_ret);
    chk("con_overflow", con_overflow, m_ovf);
    chk("con_valid", con_valid, m_vis);
    if (m_vis) begin
      chk("con_data", con_data, q[0].b);
      chk("con_chan", con_chan, q[0].ch);
    end
  endtask

  initial begin
    n_edge = 0; m_vis = 0;
    tbl[0] = '{1, 32'h0020_0000, 32'h48, 1, 0, 0, 0};
    tbl[1] = '{1, 32'h0020_0008, 32'h69, 1, 1, 8'h48, 0};
    tbl[2] = '{1, 32'h0020_000C, 32'h21, 1, 1, 8'h69, 2};
    tbl[3] = '{1, 32'h0020_0005, 32'h55, 1, 1, 8'h21, 3};
    tbl[4] = '{0, 32'h0,         32'h0,  1, 1, 8'h55, 1};
    tbl[5] = '{1, 32'h0020_0010, 32'h77, 1, 0, 0, 0};
    tbl[6] = '{0, 32'h0,         32'h0,  1, 0, 0, 0};

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 1, 1);
    repeat (4) step();
    chk("rst con_data", con_data, 0);
    chk("rst con_chan", con_chan, 0);
    rst = 1'b0;

    // Console ordering, byte-lane ignore and out-of-range channel miss
    foreach (tbl[i]) begin
      drive(tbl[i].wen, tbl[i].addr, tbl[i].data, 1, tbl[i].rdy);
      step();
      chk("tbl con_valid", con_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl con_data", con_data, tbl[i].ed);
        chk("tbl con_chan", con_chan, tbl[i].ec);
      end
    end
    chk("tbl con_overflow", con_overflow, 0);

    // Overflow: 17 writes with no drain, then push+pop every cycle while full
    rst = 1'b1; drive(0, 0, 0, 1, 0); step(); rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1, CON_BASE + 32'(4 * (i % 4)), 32'(8'h10 + i), 1, 0);
      step();
      if (i == 15) chk("ovf after 16", con_overflow, 0);
    end
    chk("ovf after 17", con_overflow, 1);
    chk("ovf head", con_data, 8'h10);
    for (int j = 0; j < 20; j++) begin
      drive(1, CON_BASE + 32'(4 * (j % 4)), 32'(8'hA0 + j), 1, 1);
      step();
    end
    chk("steady full size", q.size(), DEPTH);
    drive(0, 0, 0, 1, 1);
    repeat (20) step();

    // Random traffic against the model
    rst = 1'b1; drive(0, 0, 0, 1, 0); step(); rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0, 1:    a = CON_BASE + 32'($urandom_range(0, 19));
        2:       a = FIN + 32'($urandom_range(1, 3));
        default: a = $urandom | 32'h8000_0000;
      endcase
      drive($urandom_range(0, 1) == 1, a, $urandom,
            $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
      step();
    end

    // Finish at cycle 100 with 5 bytes queued, then reset mid-operation
    rst = 1'b1; drive(0, 0, 0, 1, 0); step(); rst = 1'b0;
    for (int i = 0; i < 99; i++) begin
      drive(i < 5, CON_BASE + 32'(4 * (i % 4)), 32'(8'h30 + i), 1, 0);
      step();
    end
    drive(1, FIN, 32'h0000_002A, 1, 0);
    step();
    chk("fin state", state, 2'b01);
    chk("fin done", done, 1);
    chk("fin exit_code", exit_code, 32'h2A);
    chk("fin cycle_count", cycle_count, 100);
    repeat (3) begin
      drive(1, CON_BASE, 32'h99, 1, 0);
      step();
    end
    chk("fin frozen cycles", cycle_count, 100);
    chk("fin no enqueue", q.size(), 5);
    rst = 1'b1; drive(0, 0, 0, 1, 1); step();
    chk("mid rst state", state, 0);
    chk("mid rst con_valid", con_valid, 0);
    chk("mid rst cycle_count", cycle_count, 0);
    chk("mid rst retire_count", retire_count, 0);
    chk("mid rst con_overflow", con_overflow, 0);
    chk("mid rst exit_code", exit_code, 0);
    rst = 1'b0;

    // Watchdog: retire on idle cycle 7 restarts, expiry on 8th idle edge
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0); step();
    repeat (6) begin drive(0, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 1, 0); step();
    chk("wdog restart", state, 0);
    repeat (7) begin drive(0, 0, 0, 0, 0); step(); end
    chk("wdog idle 7", state, 0);
    drive(0, 0, 0, 0, 0); step();
    chk("wdog idle 8", state, 2'b10);
    drive(1, FIN, 32'h5, 1, 0); step();
    chk("wdog terminal", state, 2'b10);

    // Race: finish hit on the expiring cycle
    rst = 1'b1; drive(0, 0, 0, 1, 0); step(); rst = 1'b0;
    repeat (7) begin drive(0, 0, 0, 0, 0); step(); end
    drive(1, FIN, 32'hDEAD_BEEF, 0, 0); step();
    chk("race state", state, 2'b01);
    chk("race exit_code", exit_code, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
